sd_block_reader: RTL and testbench

Single-block SD card read sequencer for the floppy subsystem. Sits directly upstream of the SPI byte engine: issues CMD17, polls for the R1 response and the data start token, then streams the 512 data bytes to the disk buffer one byte at a time. Owns the card chip select.

---
 rtl/sd_pkg.sv | 45 ++++
 rtl/sd_spi_xfer.sv | 53 +++++
 rtl/sd_block_reader.sv | 163 ++++++++++++++++
 tb/tb_sd_block_reader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared constants, error codes and state encodings for the SD single-block reader.
package sd_pkg;

  localparam logic [7:0] CMD17       = 8'h51;
  localparam logic [7:0] TOKEN_START = 8'hFE;
  localparam logic [7:0] DUMMY       = 8'hFF;

  localparam logic [1:0] ERR_OK         = 2'd0;
  localparam logic [1:0] ERR_R1_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_R1_NONZERO = 2'd2;
  localparam logic [1:0] ERR_TOKEN      = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_R1,
    ST_TOKEN,
    ST_DATA,
    ST_CRC,
    ST_RELEASE,
    ST_DONE
  } rd_state_t;

  typedef enum logic [1:0] {
    XF_IDLE,
    XF_WR,
    XF_WAIT
  } xf_state_t;

  // Byte idx of the six-byte CMD17 frame; the last slot is the dummy CRC.
  function automatic logic [7:0] cmd_byte(input logic [31:0] a, input logic [2:0] idx);
    logic [7:0] b;
    b = DUMMY;
    unique case (idx)
      3'd0:    b = CMD17;
      3'd1:    b = a[31:24];
      3'd2:    b = a[23:16];
      3'd3:    b = a[15:8];
      3'd4:    b = a[7:0];
      default: b = DUMMY;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sd_spi_xfer.sv
// One-byte handshake with the SPI byte engine: req/tx in, ack/rx out.
module sd_spi_xfer
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_req,
  input  logic [7:0] i_tx,
  output logic       o_ack,
  output logic [7:0] o_rx,
  input  logic       i_spi_ce,
  output logic [7:0] o_spi_di,
  output logic       o_spi_wr,
  input  logic [7:0] i_spi_do,
  input  logic       i_spi_dsr
);

  xf_state_t  r_state;
  xf_state_t  w_next;
  logic [7:0] r_di;
  logic       w_take;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= XF_IDLE;
    else          r_state <= w_next;
  end

  // A new request may be chained on the same cycle the previous byte is acked.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      XF_IDLE: if (i_req)     w_next = XF_WR;
      XF_WR:   if (i_spi_ce)  w_next = XF_WAIT;
      XF_WAIT: if (i_spi_dsr) w_next = i_req ? XF_WR : XF_IDLE;
      default:                w_next = XF_IDLE;
    endcase
  end

  always_comb begin
    o_spi_wr = (r_state == XF_WR) && i_spi_ce;
    o_ack    = (r_state == XF_WAIT) && i_spi_dsr;
    w_take   = i_req && ((r_state == XF_IDLE) || o_ack);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_di <= DUMMY;
    else if (w_take) r_di <= i_tx;
  end

  assign o_spi_di = r_di;
  assign o_rx     = i_spi_do;

endmodule

// File: rtl/sd_block_reader.sv
// CMD17 single-block read sequencer: command, R1 poll, token poll, 512 data bytes, CRC, release.
module sd_block_reader
  import sd_pkg::*;
#(
  parameter int unsigned R1_TRIES    = 8,
  parameter int unsigned TOKEN_TRIES = 4095
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] arg,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err_code,
  output logic [7:0]  r1,
  output logic [7:0]  data_out,
  output logic        data_strobe,
  output logic [8:0]  data_addr,
  output logic        sd_cs_n,
  input  logic        spi_ce,
  output logic [7:0]  spi_di,
  output logic        spi_wr,
  input  logic [7:0]  spi_do,
  input  logic        spi_dsr
);

  localparam logic [11:0] R1_LAST  = 12'(R1_TRIES - 1);
  localparam logic [11:0] TOK_LAST = 12'(TOKEN_TRIES - 1);

  rd_state_t   r_state;
  rd_state_t   w_next;
  logic [31:0] r_arg;
  logic [8:0]  r_cnt;
  logic [11:0] r_poll;
  logic [1:0]  r_err;
  logic [7:0]  r_r1;
  logic [7:0]  r_data;
  logic        r_strobe;
  logic [8:0]  r_addr;
  logic        r_cs_n;
  logic        w_req;
  logic [7:0]  w_tx;
  logic        w_ack;
  logic [7:0]  w_rx;

  sd_spi_xfer u_xfer (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_req     (w_req),
    .i_tx      (w_tx),
    .o_ack     (w_ack),
    .o_rx      (w_rx),
    .i_spi_ce  (spi_ce),
    .o_spi_di  (spi_di),
    .o_spi_wr  (spi_wr),
    .i_spi_do  (spi_do),
    .i_spi_dsr (spi_dsr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_next = ST_CMD;
      ST_CMD:   if (w_ack && (r_cnt == 9'd5)) w_next = ST_R1;
      ST_R1:    if (w_ack) begin
        if (!w_rx[7])                 w_next = (w_rx == 8'h00) ? ST_TOKEN : ST_RELEASE;
        else if (r_poll == R1_LAST)   w_next = ST_RELEASE;
      end
      ST_TOKEN: if (w_ack) begin
        if (w_rx == TOKEN_START)                       w_next = ST_DATA;
        else if ((w_rx != DUMMY) || (r_poll == TOK_LAST)) w_next = ST_RELEASE;
      end
      ST_DATA:    if (w_ack && (r_cnt == 9'd511)) w_next = ST_CRC;
      ST_CRC:     if (w_ack && (r_cnt == 9'd1))   w_next = ST_RELEASE;
      ST_RELEASE: if (w_ack)                      w_next = ST_DONE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Every acked byte outside RELEASE leads to another byte, so the next request is chained directly.
  always_comb begin
    w_req = 1'b0;
    w_tx  = DUMMY;
    busy  = (r_state != ST_IDLE) && (r_state != ST_DONE);
    done  = (r_state == ST_DONE);
    unique case (r_state)
      ST_IDLE: if (start) begin
        w_req = 1'b1;
        w_tx  = CMD17;
      end
      ST_CMD: if (w_ack) begin
        w_req = 1'b1;
        w_tx  = cmd_byte(r_arg, r_cnt[2:0] + 3'd1);
      end
      ST_R1, ST_TOKEN, ST_DATA, ST_CRC: w_req = w_ack;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arg    <= '0;
      r_cnt    <= '0;
      r_poll   <= '0;
      r_err    <= ERR_OK;
      r_r1     <= DUMMY;
      r_data   <= '0;
      r_strobe <= 1'b0;
      r_addr   <= '0;
      r_cs_n   <= 1'b1;
    end else begin
      r_strobe <= 1'b0;
      r_cs_n   <= !(w_next inside {ST_CMD, ST_R1, ST_TOKEN, ST_DATA, ST_CRC});

      if ((r_state == ST_IDLE) && start) begin
        r_arg <= arg;
        r_err <= ERR_OK;
      end

      if (r_state == ST_IDLE)
        r_cnt <= '0;
      else if (w_ack && (r_state inside {ST_CMD, ST_DATA, ST_CRC}))
        r_cnt <= (w_next == ST_R1) ? '0 : r_cnt + 9'd1;

      if ((w_next != r_state) && (w_next inside {ST_R1, ST_TOKEN}))
        r_poll <= '0;
      else if (w_ack && (r_state inside {ST_R1, ST_TOKEN}))
        r_poll <= r_poll + 12'd1;

      if (w_ack && (r_state == ST_R1)) begin
        if (!w_rx[7]) begin
          r_r1 <= w_rx;
          if (w_rx != 8'h00) r_err <= ERR_R1_NONZERO;
        end else if (r_poll == R1_LAST) begin
          r_err <= ERR_R1_TIMEOUT;
        end
      end

      if (w_ack && (r_state == ST_TOKEN) && (w_next == ST_RELEASE))
        r_err <= ERR_TOKEN;

      if (w_ack && (r_state == ST_DATA)) begin
        r_data   <= w_rx;
        r_addr   <= r_cnt;
        r_strobe <= 1'b1;
      end
    end
  end

  assign err_code    = r_err;
  assign r1          = r_r1;
  assign data_out    = r_data;
  assign data_strobe = r_strobe;
  assign data_addr   = r_addr;
  assign sd_cs_n     = r_cs_n;

endmodule

// File: tb/tb_sd_block_reader.sv
// Bench for sd_block_reader: SPI engine + card model, protocol-level reference and per-cycle compare.
module tb_sd_block_reader;

  localparam int R1N  = 8;
  localparam int TOKN = 4095;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] arg = '0;
  logic        busy, done, data_strobe, sd_cs_n, spi_wr;
  logic [1:0]  err_code;
  logic [7:0]  r1, data_out, spi_di;
  logic [8:0]  data_addr;
  logic        spi_ce = 1'b1;
  logic [7:0]  spi_do = 8'hFF;
  logic        spi_dsr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] resp[$];
  logic [8:0] exp_tx[$];
  logic [7:0] exp_data[$];
  logic [8:0] sent_log[$];
  logic [1:0] exp_err;
  logic [7:0] exp_r1;
  logic [7:0] last_r1 = 8'hFF;
  int         tx_n = 0;
  int         ds_n = 0;
  logic       in_op = 1'b0;
  int         ce_mode = 0;

  sd_block_reader #(.R1_TRIES(R1N), .TOKEN_TRIES(TOKN)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .arg(arg),
    .busy(busy), .done(done), .err_code(err_code), .r1(r1),
    .data_out(data_out), .data_strobe(data_strobe), .data_addr(data_addr),
    .sd_cs_n(sd_cs_n), .spi_ce(spi_ce), .spi_di(spi_di), .spi_wr(spi_wr),
    .spi_do(spi_do), .spi_dsr(spi_dsr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] card(input int k);
    return (k < resp.size()) ? resp[k] : 8'hFF;
  endfunction

  // Reference: walk the card's reply stream the way the protocol reads it.
  task automatic build_model(input logic [31:0] a);
    int p; int t; logic [7:0] b; bit got;
    exp_tx.delete();
    exp_data.delete();
    exp_tx.push_back({1'b0, 8'h51});
    for (int k = 3; k >= 0; k--) exp_tx.push_back({1'b0, a[8*k +: 8]});
    exp_tx.push_back({1'b0, 8'hFF});
    p = 0; got = 0; exp_r1 = last_r1; exp_err = 2'd1;
    while (!got && p < R1N) begin
      b = card(p); p++;
      exp_tx.push_back(9'h0FF);
      if (!b[7]) begin got = 1; exp_r1 = b; exp_err = (b == 8'h00) ? 2'd0 : 2'd2; end
    end
    if (got && exp_err == 2'd0) begin
      got = 0; t = 0; exp_err = 2'd3;
      while (!got && t < TOKN) begin
        b = card(p); p++; t++;
        exp_tx.push_back(9'h0FF);
        if (b == 8'hFE) begin got = 1; exp_err = 2'd0; end
        else if (b != 8'hFF) t = TOKN;
      end
      if (got) begin
        for (int i = 0; i < 512; i++) begin
          exp_data.push_back(card(p)); p++;
          exp_tx.push_back(9'h0FF);
        end
        exp_tx.push_back(9'h0FF);
        exp_tx.push_back(9'h0FF);
      end
    end
    exp_tx.push_back({1'b1, 8'hFF});
  endtask

  task automatic fill_nominal();
    resp.delete();
    resp.push_back(8'h00); resp.push_back(8'hFF); resp.push_back(8'hFF); resp.push_back(8'hFE);
    for (int i = 0; i < 512; i++) resp.push_back(8'(i));
    resp.push_back(8'hA5); resp.push_back(8'h5A);
  endtask

  // SPI engine + card: accepts on spi_wr&spi_ce, answers after a random delay, leaves dsr high until next accept.
  initial begin : engine
    bit w; bit pend; int lat; int eng_n;
    pend = 0; lat = 0; eng_n = 0;
    forever begin
      @(negedge clk);
      w = spi_wr && spi_ce;
      if (start && !busy) eng_n = 0;
      @(posedge clk); #1;
      if (!reset_n) begin
        spi_dsr = 1'b0; pend = 0;
      end else if (w) begin
        spi_dsr = 1'b0; pend = 1; lat = $urandom_range(0, 3);
      end else if (pend) begin
        if (lat == 0) begin
          spi_do = (eng_n < 6) ? 8'hFF : card(eng_n - 6);
          spi_dsr = 1'b1; pend = 0; eng_n++;
        end else lat--;
      end
    end
  end

  initial begin : ce_gen
    int ph;
    ph = 0;
    forever begin
      @(posedge clk); #1;
      case (ce_mode)
        0:       spi_ce = 1'b1;
        1:       spi_ce = (ph == 0);
        default: spi_ce = 1'($urandom_range(0, 1));
      endcase
      ph = (ph + 1) % 4;
    end
  end

  initial begin : compare
    logic prev_wr;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (start && !in_op) begin tx_n = 0; ds_n = 0; sent_log.delete(); end
      chk("busy", busy, in_op && !done);
      if (!in_op) chk("done_spurious", done, 0);
      if (spi_wr) begin
        chk("wr_ce", spi_ce, 1);
        chk("wr_single", prev_wr, 0);
        sent_log.push_back({sd_cs_n, spi_di});
        if (tx_n < exp_tx.size()) chk($sformatf("tx%0d", tx_n), {sd_cs_n, spi_di}, exp_tx[tx_n]);
        else chk("tx_extra", tx_n, exp_tx.size());
        tx_n++;
      end
      prev_wr = spi_wr;
      if (data_strobe) begin
        if (ds_n < exp_data.size()) begin
          chk("data_out", data_out, exp_data[ds_n]);
          chk("data_addr", data_addr, ds_n);
        end else chk("strobe_extra", ds_n, exp_data.size());
        ds_n++;
      end
      if (done && in_op) begin
        chk("err_code", err_code, exp_err);
        chk("r1", r1, exp_r1);
        chk("tx_count", tx_n, exp_tx.size());
        chk("strobe_count", ds_n, exp_data.size());
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input int exp_total, input string tag,
                        input bit poke_mid, input bit poke_done);
    int cyc;
    build_model(a);
    @(posedge clk); #1; arg = a; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; in_op = 1'b1; arg = $urandom();
    cyc = 0;
    while (!done && cyc < 60000) begin
      @(negedge clk); cyc++;
      if (poke_mid && cyc == 40) start = 1'b1;
      if (poke_mid && cyc == 41) start = 1'b0;
    end
    chk({tag, "_done"}, done, 1);
    if (exp_total >= 0) chk({tag, "_total"}, tx_n, exp_total);
    if (poke_done) start = 1'b1;
    @(posedge clk); #1; start = 1'b0; in_op = 1'b0; last_r1 = exp_r1;
    if (!done && cyc >= 60000) begin
      reset_n = 1'b0; last_r1 = 8'hFF;
      @(posedge clk); #1; reset_n = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 chk({tag, "_err_hold"}, err_code, exp_err);
  endtask

  initial begin
    logic [8:0] lit [6];
    int cyc;
    lit[0] = 9'h051; lit[1] = 9'h000; lit[2] = 9'h000;
    lit[3] = 9'h002; lit[4] = 9'h000; lit[5] = 9'h0FF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);        chk("rst_done", done, 0);
    chk("rst_err", err_code, 0);     chk("rst_r1", r1, 8'hFF);
    chk("rst_data", data_out, 0);    chk("rst_strobe", data_strobe, 0);
    chk("rst_addr", data_addr, 0);   chk("rst_cs_n", sd_cs_n, 1);
    chk("rst_spi_di", spi_di, 8'hFF); chk("rst_spi_wr", spi_wr, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    ce_mode = 0;
    fill_nominal();
    run_op(32'h0000_0200, 525, "nominal", 0, 0);
    for (int i = 0; i < 6; i++) chk($sformatf("nom_cmd%0d", i), sent_log[i], lit[i]);
    chk("nom_last_cs", sent_log[sent_log.size() - 1], 9'h1FF);
    chk("nom_strobes", ds_n, 512);
    chk("nom_err", err_code, 0);

    resp.delete(); resp.push_back(8'h05);
    run_op($urandom(), 8, "r1err", 0, 0);
    chk("r1err_r1", r1, 8'h05);
    chk("r1err_err", err_code, 2);
    chk("r1err_strobes", ds_n, 0);
    chk("r1err_release", sent_log[sent_log.size() - 1], 9'h1FF);

    resp.delete();
    run_op($urandom(), 15, "r1tmo", 0, 0);
    chk("r1tmo_err", err_code, 1);

    resp.delete(); resp.push_back(8'h00); resp.push_back(8'h09);
    run_op($urandom(), 9, "tokerr", 0, 0);
    chk("tokerr_err", err_code, 3);

    resp.delete(); resp.push_back(8'h00);
    run_op($urandom(), 4103, "toktmo", 0, 0);
    chk("toktmo_err", err_code, 3);

    ce_mode = 1;
    fill_nominal();
    run_op(32'h0000_0200, 525, "throttle", 1, 1);
    chk("thr_strobes", ds_n, 512);
    chk("thr_err", err_code, 0);

    ce_mode = 0;
    fill_nominal();
    build_model(32'h0000_0400);
    @(posedge clk); #1; arg = 32'h0000_0400; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; in_op = 1'b1;
    cyc = 0;
    while (ds_n < 100 && cyc < 60000) begin @(negedge clk); cyc++; end
    chk("rst_mid_reached", ds_n >= 100, 1);
    #2 reset_n = 1'b0; in_op = 1'b0;
    #1 chk("rst_mid_cs_n", sd_cs_n, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_wr", spi_wr, 0);
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b1; last_r1 = 8'hFF;
    repeat (2) @(posedge clk);

    ce_mode = 2;
    fill_nominal();
    run_op($urandom(), 525, "after_rst", 0, 0);
    chk("after_rst_strobes", ds_n, 512);

    for (int s = 0; s < 4; s++) begin
      resp.delete();
      repeat ($urandom_range(0, 7)) resp.push_back(8'hFF);
      if ($urandom_range(0, 3) == 0) resp.push_back({1'b0, 7'($urandom_range(1, 127))});
      else begin
        resp.push_back(8'h00);
        repeat ($urandom_range(0, 20)) resp.push_back(8'hFF);
        resp.push_back(8'hFE);
        repeat (514) resp.push_back(8'($urandom()));
      end
      run_op($urandom(), -1, $sformatf("rand%0d", s), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
